// File: rtl/fir_ntap_approx_if.sv
// Sample/coefficient/result bundle for fir_ntap_approx.
// master drives samples and coefficient writes; slave is the filter.
interface fir_ntap_approx_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 16
);
  localparam int AW = $clog2(TAPS);

  logic                     In_valid;
  logic signed [DATA_W-1:0] Xin;
  logic                     Coef_we;
  logic [AW-1:0]            Coef_addr;
  logic signed [COEF_W-1:0] Coef_data;
  logic                     Out_valid;
  logic signed [OUT_W-1:0]  Yout;

  modport master (
    output In_valid, Xin, Coef_we, Coef_addr, Coef_data,
    input  Out_valid, Yout
  );

  modport slave (
    input  In_valid, Xin, Coef_we, Coef_addr, Coef_data,
    output Out_valid, Yout
  );
endinterface

// File: rtl/fir_ntap_approx.sv
// N-tap signed direct-form FIR, 2-stage pipeline, lower-part approximate final adder.
// Define FIR_SAT_EN to saturate the output instead of wrapping it.
module fir_ntap_approx #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int TAPS     = 4,
  parameter int OUT_W    = 16,
  parameter int APPROX_K = 3,
  parameter logic [TAPS*COEF_W-1:0] COEF_INIT = {8'sd4, 8'sd3, -8'sd1, -8'sd2}
) (
  input  logic               Clk,
  input  logic               Rst_n,
  fir_ntap_approx_if.slave   bus
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int AW    = $clog2(TAPS);

  logic signed [DATA_W-1:0] x    [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  prod [TAPS];
  logic signed [ACC_W-1:0]  a_d;
  logic signed [ACC_W-1:0]  a_q;
  logic signed [ACC_W-1:0]  b_q;
  logic                     v0;
  logic                     v1;
  logic [ACC_W-1:0]         sum;
  logic [OUT_W-1:0]         y_fmt;
  logic                     out_valid_q;
  logic [OUT_W-1:0]         yout_q;

  function automatic logic signed [ACC_W-1:0] mul_ext(
    input logic signed [COEF_W-1:0] c,
    input logic signed [DATA_W-1:0] d
  );
    logic signed [ACC_W-1:0] ce;
    logic signed [ACC_W-1:0] de;
    ce = {{(ACC_W-COEF_W){c[COEF_W-1]}}, c};
    de = {{(ACC_W-DATA_W){d[DATA_W-1]}}, d};
    return ce * de;
  endfunction

  // Sample delay line and coefficient bank share the capture edge, so a
  // coefficient written alongside a sample is already used for that sample.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        x[i]    <= '0;
        coef[i] <= COEF_INIT[i*COEF_W +: COEF_W];
      end
      v0 <= 1'b0;
    end else begin
      if (bus.In_valid) begin
        x[0] <= bus.Xin;
        for (int unsigned i = 1; i < TAPS; i++) begin
          x[i] <= x[i-1];
        end
      end
      for (int unsigned i = 0; i < TAPS; i++) begin
        if (bus.Coef_we && (bus.Coef_addr == AW'(i))) begin
          coef[i] <= bus.Coef_data;
        end
      end
      v0 <= bus.In_valid;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < TAPS; i++) begin
      prod[i] = mul_ext(coef[i], x[i]);
    end
  end

  always_comb begin
    a_d = '0;
    for (int unsigned i = 1; i < TAPS; i++) begin
      a_d = a_d + prod[i];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v1  <= 1'b0;
    end else begin
      if (v0) begin
        a_q <= a_d;
        b_q <= prod[0];
      end
      v1 <= v0;
    end
  end

  // Low part carries nothing into the high part; it saturates to all-ones
  // whenever the operands disagree at bit K.
  generate
    if (APPROX_K == 0) begin : g_exact
      always_comb begin
        sum = a_q + b_q;
      end
    end else begin : g_approx
      logic [ACC_W-APPROX_K-1:0] hi;
      logic [APPROX_K-1:0]       lo;
      always_comb begin
        hi = a_q[ACC_W-1:APPROX_K] + b_q[ACC_W-1:APPROX_K];
        if (a_q[APPROX_K] ^ b_q[APPROX_K]) begin
          lo = '1;
        end else begin
          lo = a_q[APPROX_K-1:0] + b_q[APPROX_K-1:0];
        end
        sum = {hi, lo};
      end
    end
  endgenerate

`ifdef FIR_SAT_EN
  logic [ACC_W-OUT_W:0] top_bits;
  always_comb begin
    top_bits = sum[ACC_W-1:OUT_W-1];
    if ((&top_bits) || (~|top_bits)) begin
      y_fmt = sum[OUT_W-1:0];
    end else if (sum[ACC_W-1]) begin
      y_fmt = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      y_fmt = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic sum_unused;
  always_comb begin
    y_fmt      = sum[OUT_W-1:0];
    sum_unused = ^sum;
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      yout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (v1) begin
        yout_q <= y_fmt;
      end
      out_valid_q <= v1;
    end
  end

  always_comb begin
    bus.Out_valid = out_valid_q;
    bus.Yout      = yout_q;
  end

endmodule

// File: tb/tb_fir_ntap_approx.sv
// Drives an exact (K=0) and an approximate (K=3) filter in lockstep against an
// arithmetic reference model of the filter equation and the approximate adder rule.
module tb_fir_ntap_approx;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 4;
  localparam int OUT_W  = 16;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int AW     = $clog2(TAPS);

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fir_ntap_approx_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus0 ();
  fir_ntap_approx_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus3 ();

  fir_ntap_approx #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .APPROX_K(0))
    u_exact (.Clk(clk), .Rst_n(rst_n), .bus(bus0.slave));
  fir_ntap_approx #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .APPROX_K(3))
    u_approx (.Clk(clk), .Rst_n(rst_n), .bus(bus3.slave));

  always #5 clk = ~clk;

  // reference model state
  int               hist [TAPS];
  int               cf   [TAPS];
  bit               ev   [2];
  logic [OUT_W-1:0] ey0  [2];
  logic [OUT_W-1:0] ey3  [2];
  bit               exp_ov;
  logic [OUT_W-1:0] exp_y0;
  logic [OUT_W-1:0] exp_y3;

  function automatic logic [OUT_W-1:0] model_y(input int k);
    longint a, b, m, pk, ua, ub, r, s;
    a = 0;
    for (int i = 1; i < TAPS; i++) a += longint'(cf[i]) * longint'(hist[i]);
    b  = longint'(cf[0]) * longint'(hist[0]);
    m  = longint'(1) << ACC_W;
    ua = ((a % m) + m) % m;
    ub = ((b % m) + m) % m;
    if (k == 0) begin
      r = (ua + ub) % m;
    end else begin
      pk = longint'(1) << k;
      r  = (((ua / pk) + (ub / pk)) % (m / pk)) * pk;
      if ((((ua / pk) ^ (ub / pk)) & 1) != 0) r += pk - 1;
      else r += ((ua % pk) + (ub % pk)) % pk;
    end
    s = (r >= m / 2) ? r - m : r;
`ifdef FIR_SAT_EN
    if (s > (longint'(1) << (OUT_W-1)) - 1) s = (longint'(1) << (OUT_W-1)) - 1;
    if (s < -(longint'(1) << (OUT_W-1)))    s = -(longint'(1) << (OUT_W-1));
`endif
    return OUT_W'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    cf[0] = -2; cf[1] = -1; cf[2] = 3; cf[3] = 4;
    ev[0] = 0; ev[1] = 0;
    exp_ov = 0; exp_y0 = '0; exp_y3 = '0;
  endtask

  task automatic drive(input logic v, input logic signed [DATA_W-1:0] xin, input logic we,
                       input logic [AW-1:0] addr, input logic signed [COEF_W-1:0] data);
    logic [OUT_W-1:0] n0, n3;
    bus0.In_valid = v; bus0.Xin = xin; bus0.Coef_we = we; bus0.Coef_addr = addr; bus0.Coef_data = data;
    bus3.In_valid = v; bus3.Xin = xin; bus3.Coef_we = we; bus3.Coef_addr = addr; bus3.Coef_data = data;
    @(posedge clk);
    if (we) cf[addr] = int'(data);
    n0 = '0; n3 = '0;
    if (v) begin
      for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(xin);
      n0 = model_y(0);
      n3 = model_y(3);
    end
    exp_ov = ev[1];
    if (ev[1]) begin exp_y0 = ey0[1]; exp_y3 = ey3[1]; end
    ev[1] = ev[0]; ey0[1] = ey0[0]; ey3[1] = ey3[0];
    ev[0] = v;
    if (v) begin ey0[0] = n0; ey3[0] = n3; end
    #1;
  endtask

  task automatic reset_assert();
    rst_n = 1'b0;
    bus0.In_valid = 0; bus0.Coef_we = 0; bus3.In_valid = 0; bus3.Coef_we = 0;
    model_reset();
    #1;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_assert();
    if ({bus0.Out_valid, bus0.Yout} !== {1'b0, {OUT_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_k0 got v=%b y=%0d want v=0 y=0", bus0.Out_valid, bus0.Yout);
    end
    vectors++;
    if ({bus3.Out_valid, bus3.Yout} !== {1'b0, {OUT_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_k3 got v=%b y=%0d want v=0 y=0", bus3.Out_valid, bus3.Yout);
    end
    vectors++;
    reset_release();
    for (int j = 0; j < 3; j++) begin
      drive(0, 8'($urandom), 0, '0, '0);
      if ({bus0.Out_valid, bus0.Yout} !== {exp_ov, exp_y0}) begin
        miscompares++;
        $display("FAIL reset_idle_k0 cyc=%0d got v=%b y=%0d want v=%b y=%0d", j, bus0.Out_valid, bus0.Yout, exp_ov, $signed(exp_y0));
      end
      vectors++;
    end
  endtask

  task automatic test_impulse(input bit do_reset, input string tag);
    int w0 [4] = '{-2, -1, 3, 4};
    int w3 [4] = '{-1, -1, 3, 4};
    if (do_reset) begin reset_assert(); reset_release(); end
    for (int j = 0; j < 7; j++) begin
      drive(j < 4, (j == 0) ? 8'sd1 : 8'sd0, 0, '0, '0);
      if ({bus0.Out_valid, bus0.Yout} !== {exp_ov, exp_y0}) begin
        miscompares++;
        $display("FAIL %s_k0 cyc=%0d got v=%b y=%0d want v=%b y=%0d", tag, j, bus0.Out_valid, bus0.Yout, exp_ov, $signed(exp_y0));
      end
      vectors++;
      if ({bus3.Out_valid, bus3.Yout} !== {exp_ov, exp_y3}) begin
        miscompares++;
        $display("FAIL %s_k3 cyc=%0d got v=%b y=%0d want v=%b y=%0d", tag, j, bus3.Out_valid, bus3.Yout, exp_ov, $signed(exp_y3));
      end
      vectors++;
      if (j >= 2 && j < 6) begin
        if ({bus0.Out_valid, bus0.Yout} !== {1'b1, OUT_W'(w0[j-2])}) begin
          miscompares++;
          $display("FAIL %s_table_k0 cyc=%0d got v=%b y=%0d want v=1 y=%0d", tag, j, bus0.Out_valid, bus0.Yout, w0[j-2]);
        end
        vectors++;
        if ({bus3.Out_valid, bus3.Yout} !== {1'b1, OUT_W'(w3[j-2])}) begin
          miscompares++;
          $display("FAIL %s_table_k3 cyc=%0d got v=%b y=%0d want v=1 y=%0d", tag, j, bus3.Out_valid, bus3.Yout, w3[j-2]);
        end
        vectors++;
      end
    end
  endtask

  task automatic test_gap();
    bit valid_pat [4] = '{1, 0, 0, 1};
    reset_assert(); reset_release();
    for (int j = 0; j < 8; j++) begin
      if (j < 4) drive(valid_pat[j], (j == 0) ? 8'sd1 : (j == 3) ? 8'sd0 : 8'($urandom), 0, '0, '0);
      else       drive(0, 8'($urandom), 0, '0, '0);
      if ({bus0.Out_valid, bus0.Yout} !== {exp_ov, exp_y0}) begin
        miscompares++;
        $display("FAIL gap_k0 cyc=%0d got v=%b y=%0d want v=%b y=%0d", j, bus0.Out_valid, bus0.Yout, exp_ov, $signed(exp_y0));
      end
      vectors++;
      if ({bus3.Out_valid, bus3.Yout} !== {exp_ov, exp_y3}) begin
        miscompares++;
        $display("FAIL gap_k3 cyc=%0d got v=%b y=%0d want v=%b y=%0d", j, bus3.Out_valid, bus3.Yout, exp_ov, $signed(exp_y3));
      end
      vectors++;
      if (j == 3 || j == 4) begin
        if ({bus0.Out_valid, bus0.Yout} !== {1'b0, 16'hFFFE}) begin
          miscompares++;
          $display("FAIL gap_hold cyc=%0d got v=%b y=%0d want v=0 y=-2", j, bus0.Out_valid, bus0.Yout);
        end
        vectors++;
      end
      if (j == 5) begin
        if ({bus0.Out_valid, bus0.Yout} !== {1'b1, 16'hFFFF}) begin
          miscompares++;
          $display("FAIL gap_second got v=%b y=%0d want v=1 y=-1", bus0.Out_valid, bus0.Yout);
        end
        vectors++;
      end
    end
  endtask

  task automatic test_coef_same_cycle();
    reset_assert(); reset_release();
    for (int j = 0; j < 4; j++) begin
      if (j == 0) drive(1, 8'sd2, 1, 2'd0, 8'sd5);
      else        drive(0, 8'($urandom), 0, '0, '0);
      if ({bus0.Out_valid, bus0.Yout} !== {exp_ov, exp_y0}) begin
        miscompares++;
        $display("FAIL coef_same_k0 cyc=%0d got v=%b y=%0d want v=%b y=%0d", j, bus0.Out_valid, bus0.Yout, exp_ov, $signed(exp_y0));
      end
      vectors++;
      if ({bus3.Out_valid, bus3.Yout} !== {exp_ov, exp_y3}) begin
        miscompares++;
        $display("FAIL coef_same_k3 cyc=%0d got v=%b y=%0d want v=%b y=%0d", j, bus3.Out_valid, bus3.Yout, exp_ov, $signed(exp_y3));
      end
      vectors++;
      if (j == 2 && ({bus0.Out_valid, bus0.Yout} !== {1'b1, 16'd10})) begin
        miscompares++;
        $display("FAIL coef_same_value got v=%b y=%0d want v=1 y=10", bus0.Out_valid, bus0.Yout);
      end
      if (j == 2) vectors++;
    end
  endtask

  task automatic test_saturation();
    logic [OUT_W-1:0] want;
`ifdef FIR_SAT_EN
    want = 16'h8000;
`else
    want = 16'h0200;
`endif
    reset_assert(); reset_release();
    for (int i = 0; i < TAPS; i++) drive(0, 8'($urandom), 1, AW'(i), 8'sd127);
    for (int j = 0; j < 6; j++) begin
      drive(j < 4, -8'sd128, 0, '0, '0);
      if ({bus0.Out_valid, bus0.Yout} !== {exp_ov, exp_y0}) begin
        miscompares++;
        $display("FAIL sat_k0 cyc=%0d got v=%b y=%h want v=%b y=%h", j, bus0.Out_valid, bus0.Yout, exp_ov, exp_y0);
      end
      vectors++;
      if ({bus3.Out_valid, bus3.Yout} !== {exp_ov, exp_y3}) begin
        miscompares++;
        $display("FAIL sat_k3 cyc=%0d got v=%b y=%h want v=%b y=%h", j, bus3.Out_valid, bus3.Yout, exp_ov, exp_y3);
      end
      vectors++;
      if (j == 5) begin
        if ({bus0.Out_valid, bus0.Yout} !== {1'b1, want}) begin
          miscompares++;
          $display("FAIL sat_fourth got v=%b y=%h want v=1 y=%h", bus0.Out_valid, bus0.Yout, want);
        end
        vectors++;
      end
    end
  endtask

  task automatic test_random(input int n, input int idle_pct, input string tag);
    for (int j = 0; j < n; j++) begin
      drive(32'($urandom_range(0, 99)) >= idle_pct, 8'($urandom),
            $urandom_range(0, 7) == 0, AW'($urandom), 8'($urandom));
      if ({bus0.Out_valid, bus0.Yout} !== {exp_ov, exp_y0}) begin
        miscompares++;
        $display("FAIL %s_k0 cyc=%0d got v=%b y=%0d want v=%b y=%0d", tag, j, bus0.Out_valid, bus0.Yout, exp_ov, $signed(exp_y0));
      end
      vectors++;
      if ({bus3.Out_valid, bus3.Yout} !== {exp_ov, exp_y3}) begin
        miscompares++;
        $display("FAIL %s_k3 cyc=%0d got v=%b y=%0d want v=%b y=%0d", tag, j, bus3.Out_valid, bus3.Yout, exp_ov, $signed(exp_y3));
      end
      vectors++;
    end
  endtask

  task automatic test_reset_midstream();
    int xs [6] = '{3, -5, 7, 11, 13, -17};
    reset_assert(); reset_release();
    drive(0, 8'sd0, 1, 2'd2, -8'sd50);
    for (int j = 0; j < 6; j++) begin
      drive(1, 8'(xs[j]), 0, '0, '0);
      if ({bus0.Out_valid, bus0.Yout} !== {exp_ov, exp_y0}) begin
        miscompares++;
        $display("FAIL midrst_pre_k0 cyc=%0d got v=%b y=%0d want v=%b y=%0d", j, bus0.Out_valid, bus0.Yout, exp_ov, $signed(exp_y0));
      end
      vectors++;
    end
    reset_assert();
    if ({bus0.Out_valid, bus0.Yout} !== {1'b0, {OUT_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL midrst_k0 got v=%b y=%0d want v=0 y=0", bus0.Out_valid, bus0.Yout);
    end
    vectors++;
    if ({bus3.Out_valid, bus3.Yout} !== {1'b0, {OUT_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL midrst_k3 got v=%b y=%0d want v=0 y=0", bus3.Out_valid, bus3.Yout);
    end
    vectors++;
    reset_release();
    for (int j = 0; j < 4; j++) begin
      drive(0, 8'($urandom), 0, '0, '0);
      if ({bus0.Out_valid, bus0.Yout} !== {exp_ov, exp_y0} || {bus3.Out_valid, bus3.Yout} !== {exp_ov, exp_y3}) begin
        miscompares++;
        $display("FAIL midrst_stale cyc=%0d got v=%b/%b y=%0d/%0d want v=0 y=0", j, bus0.Out_valid, bus3.Out_valid, bus0.Yout, bus3.Yout);
      end
      vectors++;
    end
    test_impulse(0, "midrst_impulse");
  endtask

  initial begin
    clk = 0;
    rst_n = 1;
    vectors = 0;
    miscompares = 0;
    bus0.In_valid = 0; bus0.Xin = '0; bus0.Coef_we = 0; bus0.Coef_addr = '0; bus0.Coef_data = '0;
    bus3.In_valid = 0; bus3.Xin = '0; bus3.Coef_we = 0; bus3.Coef_addr = '0; bus3.Coef_data = '0;
    model_reset();
    #2;
    test_reset();
    test_impulse(1, "impulse");
    test_gap();
    test_coef_same_cycle();
    test_saturation();
    test_random(40, 0, "back_to_back");
    test_random(400, 30, "random");
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
